pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I_Zicsr pipeline (IF, ID, EX, MEM, WB).
- Takes register addresses and opcodes from the ID/EX/MEM/WB pipeline registers, plus memory and trap handshakes.
- Produces per-stage stall/flush, EX operand forwarding selects and PC source select.
- Owns a small FSM for data-memory wait, timeout and trap entry, plus a stall-cycle counter.

Parameters:
XADDR, 5, register address width
XLEN, 32, stall counter width
MEM_TIMEOUT, 255, max MEM_WAIT cycles before access fault (range 1..1023)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_id_opcode  in  7  opcode of instruction in ID (raw inst[6:0])
i_id_rs1_addr  in  XADDR  ID inst[19:15]
i_id_rs2_addr  in  XADDR  ID inst[24:20]
i_ex_opcode  in  7  opcode registered by decode
i_ex_rd_addr  in  XADDR  EX destination
i_ex_rs1_addr  in  XADDR  EX source 1
i_ex_rs2_addr  in  XADDR  EX source 2
i_ex_redirect  in  1  EX resolved taken branch/JAL/JALR
i_mem_rd_addr  in  XADDR  MEM destination
i_mem_wr_en  in  1  MEM stage writes rd
i_wb_rd_addr  in  XADDR  WB destination
i_wb_wr_en  in  1  WB stage writes rd
i_mem_req  in  1  MEM stage issuing data-memory access
i_mem_ack  in  1  data memory completes access
i_trap  in  1  CSR unit requests trap entry
i_mret  in  1  CSR unit requests return (mepc)
o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem  out  1 each  hold stage register
o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_flush_mem_wb  out  1 each  load bubble
o_fwd_a, o_fwd_b  out  2  EX operand select: 00 regfile, 01 MEM result, 10 WB data
o_pc_sel  out  2  00 pc+4, 01 EX target, 10 mtvec, 11 mepc
o_trap_ack  out  1  trap/mret accepted (1-cycle pulse)
o_mem_fault  out  1  timeout pulse
o_stall_cnt  out  XLEN  stall-cycle counter

Behaviour:
- States: RUN, MEM_WAIT, TRAP. Reset: state=RUN, wait counter=0, o_stall_cnt=0.
- Outputs are combinational from state and inputs. While i_rst_n=0: all stalls=0, all flushes=1, o_pc_sel=00, pulses=0.
- Forwarding (all states), per operand:
  - 01 if i_mem_wr_en and i_mem_rd_addr==ex_rsN and rsN!=0;
  - else 10 if i_wb_wr_en and i_wb_rd_addr==ex_rsN and rsN!=0;
  - else 00. MEM beats WB.
- Load-use hazard, evaluated in RUN:
  - Condition: i_ex_opcode==0000011, i_ex_rd_addr!=0, and ex rd matches a used ID source.
  - rs1 is used unless ID opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
  - rs2 is used only for R 0110011, S 0100011, B 1100011.
  - Response: o_stall_pc=o_stall_if_id=1, o_flush_id_ex=1 for exactly one cycle. Hazard clears naturally next cycle.
- RUN priority, highest first:
  1. i_trap or i_mret: o_trap_ack=1, o_pc_sel=10 (trap) or 11 (mret); trap wins if both. Flush all four stage registers. Next state TRAP.
  2. i_mem_req and !i_mem_ack: stall pc, if_id, id_ex, ex_mem; o_flush_mem_wb=1. Wait counter=1. Next state MEM_WAIT.
  3. i_ex_redirect: o_pc_sel=01, o_flush_if_id=o_flush_id_ex=1. The load-use stall is suppressed that cycle.
  4. Load-use stall.
- i_mem_req with i_mem_ack in the same cycle: zero-wait, no stall.
- MEM_WAIT:
  - Each cycle: stall pc/if_id/id_ex/ex_mem, flush mem_wb; i_trap, i_mret and i_ex_redirect are ignored. The CSR unit holds i_trap until o_trap_ack; the EX redirect is held because EX is stalled.
  - On i_mem_ack: stalls drop that same cycle; next state RUN.
  - Otherwise, wait counter increments. If counter==MEM_TIMEOUT and no ack: o_mem_fault=1 for one cycle, flush all, o_pc_sel=10, next state TRAP.
- TRAP: one drain cycle. o_flush_if_id=o_flush_id_ex=1, o_pc_sel=00, no ack. Always returns to RUN.
- o_stall_cnt increments each cycle any o_stall_* is 1, and wraps 2^XLEN-1 -> 0.
- A reset during MEM_WAIT or TRAP returns to RUN next edge with counters cleared.

Test Plan:
- Forwarding: MEM writes x5, WB writes x5, EX rs1=5 -> o_fwd_a=01. rs1=0 with MEM rd=0, wr_en=1 -> o_fwd_a=00.
- Load-use: EX lw x3 followed by ID add x4,x3,x1 -> exactly 1 cycle of stall_pc/stall_if_id/flush_id_ex; o_stall_cnt 0->1. Repeat with ID lui x3 -> no stall.
- Redirect and load-use together: i_ex_redirect=1 with a load-use match -> o_pc_sel=01, flush_if_id=flush_id_ex=1, stall_pc=0.
- Memory wait: i_mem_req held, i_mem_ack on 4th cycle -> 3 stall cycles then RUN; stall_cnt=3; i_trap asserted in MEM_WAIT is acked only after return to RUN.
- Timeout with MEM_TIMEOUT=4 and no ack -> o_mem_fault pulses on cycle 4, o_pc_sel=10, all flushes set, then TRAP, then RUN.
- Trap priority: i_trap=i_mret=1 in RUN -> o_trap_ack=1, o_pc_sel=10; reset mid-MEM_WAIT -> RUN, stall_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and sequencing controller for a 5-stage RV32I_Zicsr pipeline
// (IF, ID, EX, MEM, WB).
//
// Features:
//   - Resolves load-use hazards.
//   - Selects EX operand forwarding.
//   - Redirects the PC for branches, traps and mret.
//   - Holds the pipeline while data memory is busy.
//   - Raises an access fault if data memory never answers.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_id_*                  opcode / source registers of the ID instruction
//   i_ex_*                  opcode / rd / sources of the EX instruction,
//                           plus the EX redirect (taken branch, JAL, JALR)
//   i_mem_rd_addr/_wr_en    MEM stage destination and write enable
//   i_wb_rd_addr/_wr_en     WB stage destination and write enable
//   i_mem_req/_ack          data-memory handshake
//   i_trap, i_mret          trap entry / return requests from the CSR unit
//   o_stall_*               hold the named stage register
//   o_flush_*               load a bubble into the named stage register
//   o_fwd_a/_b              EX operand select:
//                           00 regfile, 01 MEM result, 10 WB data
//   o_pc_sel                PC source:
//                           00 pc+4, 01 EX target, 10 mtvec, 11 mepc
//   o_trap_ack              one-cycle acceptance of trap/mret
//   o_mem_fault             one-cycle data-memory timeout indication
//   o_stall_cnt             free-running count of cycles with any stall
//
// All outputs are combinational from the current state and the inputs.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int XADDR       = 5,
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [6:0]       i_id_opcode,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic [6:0]       i_ex_opcode,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  input  logic [XADDR-1:0] i_ex_rs1_addr,
  input  logic [XADDR-1:0] i_ex_rs2_addr,
  input  logic             i_ex_redirect,
  input  logic [XADDR-1:0] i_mem_rd_addr,
  input  logic             i_mem_wr_en,
  input  logic [XADDR-1:0] i_wb_rd_addr,
  input  logic             i_wb_wr_en,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  input  logic             i_trap,
  input  logic             i_mret,
  output logic             o_stall_pc,
  output logic             o_stall_if_id,
  output logic             o_stall_id_ex,
  output logic             o_stall_ex_mem,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_flush_ex_mem,
  output logic             o_flush_mem_wb,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [1:0]       o_pc_sel,
  output logic             o_trap_ack,
  output logic             o_mem_fault,
  output logic [XLEN-1:0]  o_stall_cnt
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  localparam logic [1:0] PC_SEQ   = 2'b00;
  localparam logic [1:0] PC_EX    = 2'b01;
  localparam logic [1:0] PC_MTVEC = 2'b10;
  localparam logic [1:0] PC_MEPC  = 2'b11;

  // MEM_TIMEOUT is at most 1023, and the counter never exceeds it,
  // so 10 bits are enough.
  localparam int                WAIT_W    = 10;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [XLEN-1:0]   CNT_ONE   = XLEN'(1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_TRAP
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [WAIT_W-1:0] wait_inc;
  logic              load_use;
  logic              any_stall;

  // rs1 is a real operand for every format except U-type and JAL.
  function automatic logic rs1_used(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  // rs2 is a real operand only for R, S and B formats.
  function automatic logic rs2_used(input logic [6:0] op);
    return (op == OP_R || op == OP_S || op == OP_B);
  endfunction

  // MEM is younger than WB, so MEM has the fresher value and wins.
  // x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [XADDR-1:0] rs,
    input logic             mem_we,
    input logic [XADDR-1:0] mem_rd,
    input logic             wb_we,
    input logic [XADDR-1:0] wb_rd
  );
    if (rs == '0)                   return 2'b00;
    else if (mem_we && mem_rd == rs) return 2'b01;
    else if (wb_we && wb_rd == rs)   return 2'b10;
    else                             return 2'b00;
  endfunction

  assign o_fwd_a = fwd_sel(i_ex_rs1_addr, i_mem_wr_en, i_mem_rd_addr,
                           i_wb_wr_en, i_wb_rd_addr);
  assign o_fwd_b = fwd_sel(i_ex_rs2_addr, i_mem_wr_en, i_mem_rd_addr,
                           i_wb_wr_en, i_wb_rd_addr);

  // A load in EX cannot forward in time to the ID instruction that reads it.
  assign load_use = (i_ex_opcode == OP_LOAD) && (i_ex_rd_addr != '0) &&
                    ((rs1_used(i_id_opcode) && i_id_rs1_addr == i_ex_rd_addr) ||
                     (rs2_used(i_id_opcode) && i_id_rs2_addr == i_ex_rd_addr));

  assign wait_inc  = wait_cnt + WAIT_ONE;
  assign any_stall = o_stall_pc | o_stall_if_id | o_stall_id_ex | o_stall_ex_mem;

  always_comb begin
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_stall_ex_mem = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    o_flush_ex_mem = 1'b0;
    o_flush_mem_wb = 1'b0;
    o_pc_sel       = PC_SEQ;
    o_trap_ack     = 1'b0;
    o_mem_fault    = 1'b0;
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;

    if (!i_rst_n) begin
      // Keep every stage register bubbled while reset is held.
      o_flush_if_id  = 1'b1;
      o_flush_id_ex  = 1'b1;
      o_flush_ex_mem = 1'b1;
      o_flush_mem_wb = 1'b1;
      state_nxt      = ST_RUN;
      wait_cnt_nxt   = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (i_trap || i_mret) begin
            o_trap_ack     = 1'b1;
            o_pc_sel       = i_trap ? PC_MTVEC : PC_MEPC;
            o_flush_if_id  = 1'b1;
            o_flush_id_ex  = 1'b1;
            o_flush_ex_mem = 1'b1;
            o_flush_mem_wb = 1'b1;
            state_nxt      = ST_TRAP;
          end else if (i_mem_req && !i_mem_ack) begin
            o_stall_pc     = 1'b1;
            o_stall_if_id  = 1'b1;
            o_stall_id_ex  = 1'b1;
            o_stall_ex_mem = 1'b1;
            o_flush_mem_wb = 1'b1;
            wait_cnt_nxt   = WAIT_ONE;
            state_nxt      = ST_MEM_WAIT;
          end else if (i_ex_redirect) begin
            // The redirect squashes the ID instruction,
            // so any load-use match is moot.
            o_pc_sel      = PC_EX;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
          end else if (load_use) begin
            o_stall_pc    = 1'b1;
            o_stall_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          // Trap, mret and redirect are held by their sources
          // and are serviced after returning to RUN.
          if (i_mem_ack) begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = '0;
          end else if (wait_inc >= WAIT_LIM) begin
            o_mem_fault    = 1'b1;
            o_pc_sel       = PC_MTVEC;
            o_flush_if_id  = 1'b1;
            o_flush_id_ex  = 1'b1;
            o_flush_ex_mem = 1'b1;
            o_flush_mem_wb = 1'b1;
            state_nxt      = ST_TRAP;
            wait_cnt_nxt   = '0;
          end else begin
            o_stall_pc     = 1'b1;
            o_stall_if_id  = 1'b1;
            o_stall_id_ex  = 1'b1;
            o_stall_ex_mem = 1'b1;
            o_flush_mem_wb = 1'b1;
            wait_cnt_nxt   = wait_inc;
          end
        end

        ST_TRAP: begin
          // Drain the instructions fetched along the old path.
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
          state_nxt     = ST_RUN;
        end

        default: begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      o_stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (any_stall) begin
        o_stall_cnt <= o_stall_cnt + CNT_ONE;
      end
    end
  end

endmodule
